// File: rtl/gamepad_pkg.sv
// gamepad_pkg
// Shared definitions for the serial gamepad poller:
//   - state_t       : poller FSM state encoding (also exposed on dbg_state)
//   - BTN_*         : snapshot bit positions of the SNES buttons
//   - STAT_*        : field positions inside the status word
//   - ADDR_*        : CPU read-address map
package gamepad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_HIGH   = 3'd2,
    ST_LOW    = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  // Snapshot bit positions (first-sampled bit is bit 0)
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // Status word: {7'b0, busy, poll_count[7:0]}
  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_W   = 8;
  localparam int STAT_BUSY_BIT  = 8;

  // CPU read-address map
  localparam logic [1:0] ADDR_PAD1   = 2'd0;
  localparam logic [1:0] ADDR_PAD2   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

endpackage

// File: rtl/gamepad_pad_shift_channel.sv
// pad_shift_channel
// One pad's capture path: inverting sampler, NUM_BITS shift register written
// at bit index idx, and the 16-bit snapshot loaded on commit.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   sample       : capture ~data_n into shift bit idx this cycle
//   idx          : bit index being captured
//   commit       : copy shift register into snapshot (zero-extended)
//   data_n       : serial pad data, active-low
//   snapshot     : committed button state, 1 = pressed
module pad_shift_channel #(
  parameter int NUM_BITS = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample,
  input  logic [IDX_W-1:0] idx,
  input  logic             commit,
  input  logic             data_n,
  output logic [15:0]      snapshot
);
  import gamepad_pkg::*;

  logic [NUM_BITS-1:0] r_shift;
  logic [15:0]         r_snap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_snap  <= '0;
    end else begin
      if (sample) begin
        r_shift[idx] <= ~data_n;
      end
      // Bits at NUM_BITS and above are zero-filled by the cast.
      if (commit) begin
        r_snap <= 16'(r_shift);
      end
    end
  end

  assign snapshot = r_snap;

endmodule

// File: rtl/gamepad_poller.sv
// gamepad_poller
// Autonomous SNES-style two-pad poller. On start it drives the shared
// latch/clock lines, captures NUM_BITS bits per pad and commits them into
// CPU-readable snapshots.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start                   : single-cycle poll request (ignored while busy)
//   pad_data_in[1:0]        : serial data pad2/pad1, active-low
//   pad_latch, pad_clk      : pad control lines (pad_clk idles high)
//   read_en, read_address   : CPU read request (0 pad1, 1 pad2, 2 status, 3 zero)
//   read_data, read_ready   : registered read result, one cycle after read_en
//   busy                    : poll in progress
//   done                    : one-cycle pulse in the commit cycle
//   dbg_state               : current FSM state
// Handshake: a read is a single-cycle read_en strobe; read_ready pulses exactly
// one cycle later with read_data valid. There is no backpressure and a new read
// may be issued every cycle.
module gamepad_poller #(
  parameter int CLK_DIV      = 6,
  parameter int LATCH_CYCLES = 12,
  parameter int NUM_BITS     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  pad_data_in,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        read_en,
  input  logic [1:0]  read_address,
  output logic [15:0] read_data,
  output logic        read_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);
  import gamepad_pkg::*;

  localparam int CNT_MAX = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_BITS);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [7:0]         r_poll_count;
  logic [15:0]        r_read_data;
  logic               r_read_ready;

  logic               w_sample;
  logic               w_commit;
  logic               w_clk_last;
  logic [15:0]        w_snap1;
  logic [15:0]        w_snap2;
  logic [15:0]        w_status;
  logic [15:0]        w_read_mux;

  assign w_clk_last = (r_cnt == CNT_W'(CLK_DIV - 1));

  // Next state and Moore outputs
  always_comb begin
    w_state_next = r_state;
    pad_latch    = 1'b0;
    pad_clk      = 1'b1;
    busy         = 1'b1;
    done         = 1'b0;
    w_sample     = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = ST_LATCH;
      end
      ST_LATCH: begin
        pad_latch = 1'b1;
        if (r_cnt == CNT_W'(LATCH_CYCLES - 1)) w_state_next = ST_HIGH;
      end
      ST_HIGH: begin
        // Sample at the end of the high phase, well after the pad has
        // settled from the previous rising edge.
        if (w_clk_last) begin
          w_sample     = 1'b1;
          w_state_next = (r_idx == IDX_W'(NUM_BITS - 1)) ? ST_COMMIT : ST_LOW;
        end
      end
      ST_LOW: begin
        pad_clk = 1'b0;
        if (w_clk_last) w_state_next = ST_HIGH;
      end
      ST_COMMIT: begin
        done         = 1'b1;
        w_commit     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_poll_count <= '0;
    end else begin
      r_state <= w_state_next;
      // Phase counter restarts on every state change and stays cleared in IDLE.
      if (r_state == ST_IDLE || w_state_next != r_state) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == ST_IDLE) begin
        r_idx <= '0;
      end else if (r_state == ST_LOW && w_clk_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_commit) begin
        r_poll_count <= r_poll_count + 8'd1;
      end
    end
  end

  pad_shift_channel #(.NUM_BITS(NUM_BITS), .IDX_W(IDX_W)) u_pad1 (
    .clk      (clk),
    .reset    (reset),
    .sample   (w_sample),
    .idx      (r_idx),
    .commit   (w_commit),
    .data_n   (pad_data_in[0]),
    .snapshot (w_snap1)
  );

  pad_shift_channel #(.NUM_BITS(NUM_BITS), .IDX_W(IDX_W)) u_pad2 (
    .clk      (clk),
    .reset    (reset),
    .sample   (w_sample),
    .idx      (r_idx),
    .commit   (w_commit),
    .data_n   (pad_data_in[1]),
    .snapshot (w_snap2)
  );

  always_comb begin
    w_status = '0;
    w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = r_poll_count;
    w_status[STAT_BUSY_BIT]                  = busy;
  end

  always_comb begin
    w_read_mux = '0;
    case (read_address)
      ADDR_PAD1:   w_read_mux = w_snap1;
      ADDR_PAD2:   w_read_mux = w_snap2;
      ADDR_STATUS: w_read_mux = w_status;
      default:     w_read_mux = '0;
    endcase
  end

  // Snapshots update on the same edge as this register, so a read issued in
  // the COMMIT cycle returns the pre-commit value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data  <= '0;
      r_read_ready <= 1'b0;
    end else begin
      r_read_ready <= read_en;
      if (read_en) r_read_data <= w_read_mux;
    end
  end

  assign read_data  = r_read_data;
  assign read_ready = r_read_ready;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_gamepad_poller.sv
// tb_gamepad_poller
// Directed bench for gamepad_poller: pad serial model, table of poll
// patterns with expected snapshots, and hand-written corner sequences.
module tb_gamepad_poller;

  localparam int CLK_DIV      = 6;
  localparam int LATCH_CYCLES = 12;
  localparam int NUM_BITS     = 16;
  localparam int DONE_LAT     = 199;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  pad_data_in;
  logic        pad_latch;
  logic        pad_clk;
  logic        read_en;
  logic [1:0]  read_address;
  logic [15:0] read_data;
  logic        read_ready;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  gamepad_poller #(
    .CLK_DIV(CLK_DIV), .LATCH_CYCLES(LATCH_CYCLES), .NUM_BITS(NUM_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pad_data_in  (pad_data_in),
    .pad_latch    (pad_latch),
    .pad_clk      (pad_clk),
    .read_en      (read_en),
    .read_address (read_address),
    .read_data    (read_data),
    .read_ready   (read_ready),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- pad model ----------------
  // Latch resets the pad to its first bit; each rising pad_clk advances it.
  logic [15:0] pat1, pat2;
  logic [3:0]  m_idx;
  initial begin
    pat1  = 16'hFFFF;
    pat2  = 16'hFFFF;
    m_idx = 4'd0;
  end
  always @(posedge pad_latch) m_idx = 4'd0;
  always @(posedge pad_clk) if (pad_latch === 1'b0) m_idx = m_idx + 4'd1;
  assign pad_data_in = {pat2[m_idx], pat1[m_idx]};

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] addr, input logic [15:0] exp, input string name);
    logic [15:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    read_en      = 1'b1;
    read_address = addr;
    @(negedge clk);
    read_en = 1'b0;
    e = exp_q.pop_front();
    check({name, "_ready"}, {31'd0, read_ready}, 32'd1);
    check(name, {16'd0, read_data}, {16'd0, e});
  endtask

  // Runs one poll, measuring the pad waveforms and done timing. restart_at
  // re-pulses start in that cycle of the poll (0 = never). With commit_read a
  // pad1 read is issued in the done cycle and repeated the next cycle.
  task automatic run_poll(input logic [15:0] p1, input logic [15:0] p2,
                          input int restart_at, input bit commit_read,
                          input logic [15:0] old_snap, input logic [15:0] new_snap);
    int cyc = 0;
    int latch_cnt = 0;
    int low_pulses = 0;
    int low_run = 0;
    int bad_runs = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    pat1 = p1;
    pat2 = p2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc <= DONE_LAT + 8) begin
      start = (cyc == restart_at);
      if (pad_latch) latch_cnt++;
      if (!pad_clk) begin
        low_run++;
      end else if (low_run > 0) begin
        low_pulses++;
        if (low_run != CLK_DIV) bad_runs++;
        low_run = 0;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 1)            check("busy_rise", {31'd0, busy}, 32'd1);
      if (cyc == DONE_LAT)     check("busy_in_commit", {31'd0, busy}, 32'd1);
      if (cyc == DONE_LAT + 1) check("busy_fall", {31'd0, busy}, 32'd0);
      if (commit_read) begin
        if (done_cyc >= 0 && cyc == done_cyc + 1) begin
          check("commit_read_ready", {31'd0, read_ready}, 32'd1);
          check("commit_read_old", {16'd0, read_data}, {16'd0, old_snap});
        end
        if (done_cyc >= 0 && cyc == done_cyc + 2) begin
          check("commit_read_new", {16'd0, read_data}, {16'd0, new_snap});
        end
        read_en      = (done_cyc >= 0 && cyc <= done_cyc + 1);
        read_address = 2'd0;
      end
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    read_en = 1'b0;
    exp_count = (exp_count + 1) % 256;
    check("done_latency", done_cyc, DONE_LAT);
    check("done_pulses", done_cnt, 1);
    check("latch_cycles", latch_cnt, LATCH_CYCLES);
    check("clk_low_pulses", low_pulses, NUM_BITS - 1);
    check("clk_low_bad_width", bad_runs, 0);
    check("clk_idle_high", {31'd0, pad_clk}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } vec_t;

  vec_t vecs[3];

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    read_en      = 1'b0;
    read_address = 2'd0;

    vecs[0] = '{p1: 16'hA5C3, p2: 16'h0000, exp1: 16'h5A3C, exp2: 16'hFFFF};
    vecs[1] = '{p1: 16'hFFFF, p2: 16'hFFFF, exp1: 16'h0000, exp2: 16'h0000};
    vecs[2] = '{p1: 16'h1234, p2: 16'hFEDC, exp1: 16'hEDCB, exp2: 16'h0123};

    do_reset();

    // reset state
    check("rst_pad_latch", {31'd0, pad_latch}, 32'd0);
    check("rst_pad_clk", {31'd0, pad_clk}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_read_ready", {31'd0, read_ready}, 32'd0);
    check("rst_read_data", {16'd0, read_data}, 32'd0);
    do_read(2'd2, 16'h0000, "rst_status");

    // table of poll patterns
    for (int i = 0; i < 3; i++) begin
      run_poll(vecs[i].p1, vecs[i].p2, 0, 1'b0, 16'h0, 16'h0);
      do_read(2'd0, vecs[i].exp1, "pad1");
      do_read(2'd1, vecs[i].exp2, "pad2");
      do_read(2'd2, {8'd0, 8'(exp_count)}, "status");
      do_read(2'd3, 16'h0000, "addr3");
    end

    // start re-pulsed mid-poll is ignored
    run_poll(16'h0F0F, 16'hF0F0, 50, 1'b0, 16'h0, 16'h0);
    do_read(2'd0, 16'hF0F0, "restart_pad1");
    do_read(2'd1, 16'h0F0F, "restart_pad2");
    do_read(2'd2, 16'd4, "restart_status");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("restart_no_extra_done", {31'd0, done}, 32'd0);
    end

    // reset in cycle 100 of a poll
    do_read(2'd0, 16'hF0F0, "pre_reset_pad1");
    pat1 = 16'h0000;
    pat2 = 16'h0000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("mid_poll_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_pad_latch", {31'd0, pad_latch}, 32'd0);
    check("mrst_pad_clk", {31'd0, pad_clk}, 32'd1);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_read_data", {16'd0, read_data}, 32'd0);
    check("mrst_read_ready", {31'd0, read_ready}, 32'd0);
    begin
      int dn = 0;
      for (int i = 0; i < 250; i++) begin
        @(negedge clk);
        if (done) dn++;
      end
      check("mrst_no_done", dn, 0);
    end
    exp_count = 0;
    do_read(2'd0, 16'h0000, "mrst_pad1");
    do_read(2'd1, 16'h0000, "mrst_pad2");
    do_read(2'd2, 16'h0000, "mrst_status");

    // read coinciding with COMMIT, then back-to-back read of new value
    run_poll(16'hA5C3, 16'h0000, 0, 1'b1, 16'h0000, 16'h5A3C);
    do_read(2'd2, 16'd1, "commit_status");

    // poll_count wrap: 255 more polls brings 256 total since reset
    for (int i = 0; i < 255; i++) begin
      run_poll(16'hA5C3, 16'h0000, 0, 1'b0, 16'h0, 16'h0);
    end
    do_read(2'd2, 16'h0000, "wrap_status");
    do_read(2'd0, 16'h5A3C, "wrap_pad1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
